// File: rtl/lockstep_alu_checker.sv
// rtl/lockstep_alu_checker.sv - dual-channel lockstep ALU with registered compare and fault counting
// Optional channel-1 fault injection enabled by defining LOCKSTEP_FAULT_INJ_EN.
module lockstep_alu_checker #(
   parameter int WIDTH  = 8,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a0,
   input  logic [WIDTH-1:0]  b0,
   input  logic [WIDTH-1:0]  a1,
   input  logic [WIDTH-1:0]  b1,
   input  logic [2:0]        sel0,
   input  logic [2:0]        sel1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  res,
   output logic              carry,
   output logic [WIDTH-1:0]  diff,
   output logic              mismatch,
   output logic              fault_sticky,
   output logic [FCNT_W-1:0] fault_cnt,
   input  logic              fault_clr
`ifdef LOCKSTEP_FAULT_INJ_EN
   ,
   input  logic              inj_en,
   input  logic [WIDTH-1:0]  inj_mask
`endif
);

   localparam logic [FCNT_W-1:0] CNT_MAX = '1;
   localparam logic [FCNT_W-1:0] CNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

   logic              stall;
   logic              s1_valid;
   logic [WIDTH-1:0]  s1_a0, s1_b0, s1_a1, s1_b1;
   logic [2:0]        s1_sel0, s1_sel1;
   logic [WIDTH:0]    alu0, alu1;
   logic [WIDTH-1:0]  res1;
   logic [WIDTH-1:0]  diff_next;
   logic              mismatch_next;
   logic              fault_event;

   // Result in the low WIDTH bits, carry/borrow in bit WIDTH.
   function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [2:0]       sel);
      logic [WIDTH:0] r;
      r = '0;
      case (sel)
         3'b000:  r = {1'b0, a} + {1'b0, b};
         3'b001:  r = {1'b0, a} - {1'b0, b};
         3'b010:  r = {1'b0, a & b};
         3'b011:  r = {1'b0, a | b};
         3'b100:  r = {1'b0, a ^ b};
         3'b101:  r = {a, 1'b0};
         3'b110:  r = {a[0], 1'b0, a[WIDTH-1:1]};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   assign alu0 = alu(s1_a0, s1_b0, s1_sel0);
   assign alu1 = alu(s1_a1, s1_b1, s1_sel1);

`ifdef LOCKSTEP_FAULT_INJ_EN
   assign res1 = alu1[WIDTH-1:0] ^ (inj_en ? inj_mask : {WIDTH{1'b0}});
`else
   assign res1 = alu1[WIDTH-1:0];
`endif

   assign diff_next     = alu0[WIDTH-1:0] ^ res1;
   assign mismatch_next = (diff_next != '0) || (alu0[WIDTH] != alu1[WIDTH]);
   // An entry is counted only on the cycle it moves into S2, so a stalled entry never recounts.
   assign fault_event   = !stall && s1_valid && mismatch_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a0    <= '0;
         s1_b0    <= '0;
         s1_a1    <= '0;
         s1_b1    <= '0;
         s1_sel0  <= '0;
         s1_sel1  <= '0;
      end else if (!stall) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a0   <= a0;
            s1_b0   <= b0;
            s1_a1   <= a1;
            s1_b1   <= b1;
            s1_sel0 <= sel0;
            s1_sel1 <= sel1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         res       <= '0;
         carry     <= 1'b0;
         diff      <= '0;
         mismatch  <= 1'b0;
      end else if (!stall) begin
         out_valid <= s1_valid;
         mismatch  <= s1_valid && mismatch_next;
         if (s1_valid) begin
            res   <= alu0[WIDTH-1:0];
            carry <= alu0[WIDTH];
            diff  <= diff_next;
         end
      end
   end

   // A fault landing together with a clear survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt    <= '0;
         fault_sticky <= 1'b0;
      end else if (fault_event) begin
         fault_sticky <= 1'b1;
         if (fault_clr)
            fault_cnt <= CNT_ONE;
         else if (fault_cnt != CNT_MAX)
            fault_cnt <= fault_cnt + CNT_ONE;
      end else if (fault_clr) begin
         fault_cnt    <= '0;
         fault_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lockstep_alu_checker.sv
// tb/tb_lockstep_alu_checker.sv - directed bench with a pipeline-time model for lockstep_alu_checker
// Exercises the injection ports when LOCKSTEP_FAULT_INJ_EN is defined.
module tb_lockstep_alu_checker;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a0, b0, a1, b1;
   logic [2:0]   sel0, sel1;
   logic         out_ready;
   logic         fault_clr;

   logic         in_ready, out_valid, carry, mismatch, fault_sticky;
   logic [W-1:0] res, diff;
   logic [7:0]   fault_cnt;

   logic         in_ready2, out_valid2, carry2, mismatch2, fault_sticky2;
   logic [W-1:0] res2, diff2;
   logic [1:0]   fault_cnt2;

`ifdef LOCKSTEP_FAULT_INJ_EN
   logic         inj_en;
   logic [W-1:0] inj_mask;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lockstep_alu_checker #(.WIDTH(W), .FCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
      .out_valid(out_valid), .out_ready(out_ready), .res(res), .carry(carry),
      .diff(diff), .mismatch(mismatch), .fault_sticky(fault_sticky),
      .fault_cnt(fault_cnt), .fault_clr(fault_clr)
`ifdef LOCKSTEP_FAULT_INJ_EN
      , .inj_en(inj_en), .inj_mask(inj_mask)
`endif
   );

   lockstep_alu_checker #(.WIDTH(W), .FCNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel0(sel0), .sel1(sel1),
      .out_valid(out_valid2), .out_ready(out_ready), .res(res2), .carry(carry2),
      .diff(diff2), .mismatch(mismatch2), .fault_sticky(fault_sticky2),
      .fault_cnt(fault_cnt2), .fault_clr(fault_clr)
`ifdef LOCKSTEP_FAULT_INJ_EN
      , .inj_en(inj_en), .inj_mask(inj_mask)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] alu_m(input int a, input int b, input int op);
      int   r;
      logic c;
      c = 1'b0;
      case (op)
         0: begin r = a + b; c = (r > 255); end
         1: begin r = a - b; c = (a < b); end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = a * 2; c = (a >= 128); end
         6: begin r = a / 2; c = (a % 2 == 1); end
         default: r = a;
      endcase
      return {c, r[7:0]};
   endfunction

   typedef struct {
      int         due;
      logic [7:0] r;
      logic       c;
      logic [7:0] d;
      logic       m;
   } ent_t;

   ent_t q[$];
   ent_t p_ent;
   logic p_iv, p_or, p_clr;
   logic live = 1'b0;
   logic exp_ov = 1'b0;
   int   ptime = 0;
   int   cnt_a = 0, cnt_b = 0;
   logic stk = 1'b0;

   // The model advances a pipeline clock only on non-stalled edges; an entry taken
   // at pipeline time t is visible at t+1 and leaves once it is accepted downstream.
   always @(negedge clk) begin
      logic stall_m, ev;
      logic [8:0] o0, o1;
      if (!rst_n) begin
         q.delete();
         ptime = 0; cnt_a = 0; cnt_b = 0; stk = 1'b0; exp_ov = 1'b0; live = 1'b0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_res", res, 0);
         chk("rst_carry", carry, 0);
         chk("rst_diff", diff, 0);
         chk("rst_mismatch", mismatch, 0);
         chk("rst_cnt", fault_cnt, 0);
         chk("rst_sticky", fault_sticky, 0);
         chk("rst_cnt2", fault_cnt2, 0);
      end else begin
         if (live) begin
            stall_m = exp_ov && !p_or;
            ev = 1'b0;
            if (!stall_m) begin
               if (exp_ov) void'(q.pop_front());
               ptime++;
               if (p_iv) begin
                  p_ent.due = ptime + 1;
                  q.push_back(p_ent);
               end
               ev = (q.size() > 0) && (q[0].due == ptime) && q[0].m;
            end
            if (ev) begin
               cnt_a = p_clr ? 1 : ((cnt_a == 255) ? 255 : cnt_a + 1);
               cnt_b = p_clr ? 1 : ((cnt_b == 3) ? 3 : cnt_b + 1);
               stk = 1'b1;
            end else if (p_clr) begin
               cnt_a = 0; cnt_b = 0; stk = 1'b0;
            end
         end
         exp_ov = (q.size() > 0) && (q[0].due == ptime);
         chk("in_ready", in_ready, !(exp_ov && !out_ready));
         chk("out_valid", out_valid, exp_ov);
         chk("out_valid2", out_valid2, exp_ov);
         if (exp_ov) begin
            chk("res", res, q[0].r);
            chk("carry", carry, q[0].c);
            chk("diff", diff, q[0].d);
            chk("mismatch", mismatch, q[0].m);
            chk("res2", res2, q[0].r);
         end else begin
            chk("idle_mismatch", mismatch, 0);
         end
         chk("fault_cnt", fault_cnt, cnt_a);
         chk("fault_cnt2", fault_cnt2, cnt_b);
         chk("fault_sticky", fault_sticky, stk);
         chk("fault_sticky2", fault_sticky2, stk);
         live = 1'b1;
      end
      o0 = alu_m(a0, b0, sel0);
      o1 = alu_m(a1, b1, sel1);
`ifdef LOCKSTEP_FAULT_INJ_EN
      if (inj_en) o1[7:0] = o1[7:0] ^ inj_mask;
`endif
      p_ent.r = o0[7:0];
      p_ent.c = o0[8];
      p_ent.d = o0[7:0] ^ o1[7:0];
      p_ent.m = (o0[7:0] != o1[7:0]) || (o0[8] != o1[8]);
      p_iv  = in_valid;
      p_or  = out_ready;
      p_clr = fault_clr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] xa0, input logic [7:0] xb0, input logic [7:0] xa1,
                        input logic [7:0] xb1, input logic [2:0] s0, input logic [2:0] s1);
      a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; sel0 = s0; sel1 = s1;
      in_valid = 1'b1;
   endtask

   // Presents one entry, then returns once it is visible at the output.
   task automatic send(input logic [7:0] xa0, input logic [7:0] xb0, input logic [7:0] xa1,
                       input logic [7:0] xb1, input logic [2:0] s0, input logic [2:0] s1);
      drive(xa0, xb0, xa1, xb1, s0, s1);
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   logic [7:0] tab_r [8];
   logic       tab_c [8];

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      tab_r = '{8'hD2, 8'h5A, 8'h14, 8'hBE, 8'hAA, 8'h2C, 8'h4B, 8'h96};
      tab_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fault_clr = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
`ifdef LOCKSTEP_FAULT_INJ_EN
      inj_en = 1'b0; inj_mask = '0;
`endif
      repeat (3) tick();
      chk("lit_rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      send(8'h05, 8'h03, 8'h05, 8'h03, 3'd0, 3'd0);
      chk("lit_t1_valid", out_valid, 1);
      chk("lit_t1_res", res, 8'h08);
      chk("lit_t1_carry", carry, 0);
      chk("lit_t1_diff", diff, 0);
      chk("lit_t1_mismatch", mismatch, 0);
      chk("lit_t1_cnt", fault_cnt, 0);

      send(8'hFF, 8'h01, 8'hFF, 8'h01, 3'd0, 3'd0);
      chk("lit_add_res", res, 8'h00);
      chk("lit_add_carry", carry, 1);
      send(8'h02, 8'h05, 8'h02, 8'h05, 3'd1, 3'd1);
      chk("lit_sub_res", res, 8'hFD);
      chk("lit_sub_borrow", carry, 1);
      chk("lit_sub_mismatch", mismatch, 0);

      for (int i = 0; i < 8; i++) begin
         send(8'h96, 8'h3C, 8'h96, 8'h3C, i[2:0], i[2:0]);
         chk($sformatf("lit_op%0d_res", i), res, tab_r[i]);
         chk($sformatf("lit_op%0d_carry", i), carry, tab_c[i]);
      end
      for (int i = 0; i < 8; i++) begin
         drive(8'(i * 37), 8'(i * 11 + 1), 8'(i * 37), 8'(i * 11 + 1), i[2:0], i[2:0]);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();

      send(8'h10, 8'h01, 8'h10, 8'h01, 3'd0, 3'd1);
      chk("lit_t3_res", res, 8'h11);
      chk("lit_t3_diff", diff, 8'h1E);
      chk("lit_t3_mismatch", mismatch, 1);
      chk("lit_t3_sticky", fault_sticky, 1);
      chk("lit_t3_cnt", fault_cnt, 1);
      tick();
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("lit_clr_cnt", fault_cnt, 0);

      out_ready = 1'b0;
      drive(8'h10, 8'h01, 8'h10, 8'h01, 3'd0, 3'd1);
      tick();
      drive(8'h20, 8'h01, 8'h20, 8'h01, 3'd0, 3'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("lit_hold_res", res, 8'h11);
         chk("lit_hold_diff", diff, 8'h1E);
         chk("lit_hold_in_ready", in_ready, 0);
         chk("lit_hold_cnt", fault_cnt, 1);
      end
      out_ready = 1'b1;
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("lit_clrwin_res", res, 8'h21);
      chk("lit_clrwin_diff", diff, 8'h3E);
      chk("lit_clrwin_cnt", fault_cnt, 1);
      chk("lit_clrwin_sticky", fault_sticky, 1);
      tick();

      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(8'(i), 8'h01, 8'(i), 8'h01, 3'd0, 3'd1);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("lit_sat_cnt2", fault_cnt2, 3);
      chk("lit_sat_cnt", fault_cnt, 6);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("lit_sat_clr_cnt2", fault_cnt2, 0);
      chk("lit_sat_clr_sticky2", fault_sticky2, 0);

      drive(8'h01, 8'h02, 8'h01, 8'h02, 3'd0, 3'd0);
      tick();
      drive(8'h03, 8'h04, 8'h03, 8'h04, 3'd0, 3'd0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("lit_midrst_valid", out_valid, 0);
      chk("lit_midrst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("lit_postrst_valid", out_valid, 0);

`ifdef LOCKSTEP_FAULT_INJ_EN
      inj_en = 1'b1; inj_mask = 8'h01;
      send(8'hA5, 8'h00, 8'hA5, 8'h00, 3'd7, 3'd7);
      chk("lit_inj_diff", diff, 8'h01);
      chk("lit_inj_mismatch", mismatch, 1);
      tick();
      inj_en = 1'b0;
      send(8'hA5, 8'h00, 8'hA5, 8'h00, 3'd7, 3'd7);
      chk("lit_noinj_mismatch", mismatch, 0);
`endif
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
